// File: rtl/fir_serial_host_if.sv
// Host-side bus bundle for the FIR serial link endpoint: parallel TX word port,
// serial out/in bit streams, parallel RX word port, word counters and enable.
interface fir_serial_host_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                  en;
    logic [DATA_WIDTH-1:0] tx_word;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  ser_dout;
    logic                  ser_dout_valid;
    logic                  ser_out_ready;
    logic                  ser_din;
    logic                  ser_din_valid;
    logic                  ser_din_ready;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [CNT_WIDTH-1:0]  tx_count;
    logic [CNT_WIDTH-1:0]  rx_count;

    // The endpoint itself
    modport slave (
        input  en, tx_word, tx_valid, ser_out_ready, ser_din, ser_din_valid, rx_ready,
        output tx_ready, ser_dout, ser_dout_valid, ser_din_ready, rx_word, rx_valid,
               tx_count, rx_count
    );

    // Whoever drives the endpoint (board logic or bench)
    modport master (
        output en, tx_word, tx_valid, ser_out_ready, ser_din, ser_din_valid, rx_ready,
        input  tx_ready, ser_dout, ser_dout_valid, ser_din_ready, rx_word, rx_valid,
               tx_count, rx_count
    );
endinterface

// File: rtl/fir_serial_host.sv
// Host-side endpoint of the FIR subsystem bit-serial link.
// TX shifts parallel words out MSB first; RX assembles incoming bits MSB first.
// rst is synchronous and active-low; while it is low every output reads 0.
// en=0 freezes both paths and masks every valid/ready so no transfer can happen.
module fir_serial_host #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    fir_serial_host_if.slave  bus
);
    localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]        BIT_ONE  = BW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic {T_IDLE, T_SHIFT}  tx_state_t;
    typedef enum logic {R_COLLECT, R_HOLD} rx_state_t;

    tx_state_t             tx_state;
    logic [DATA_WIDTH-1:0] tx_shreg;
    logic [BW-1:0]         tx_bitcnt;
    logic [CNT_WIDTH-1:0]  tx_count_q;

    rx_state_t             rx_state;
    logic [DATA_WIDTH-2:0] rx_shreg;
    logic [BW-1:0]         rx_bitcnt;
    logic [DATA_WIDTH-1:0] rx_word_q;
    logic [CNT_WIDTH-1:0]  rx_count_q;

    logic                  run;
    logic [DATA_WIDTH-1:0] rx_next;

    // Only W-1 previous bits need storing; the incoming bit completes the word.
    assign rx_next = {rx_shreg, bus.ser_din};
    assign run     = rst && bus.en;

    // Handshake outputs come from registered state, masked by reset and enable.
    assign bus.tx_ready       = run && (tx_state == T_IDLE);
    assign bus.ser_dout_valid = run && (tx_state == T_SHIFT);
    assign bus.ser_dout       = rst && tx_shreg[DATA_WIDTH-1];
    assign bus.ser_din_ready  = run && (rx_state == R_COLLECT);
    assign bus.rx_valid       = run && (rx_state == R_HOLD);
    assign bus.rx_word        = rst ? rx_word_q  : '0;
    assign bus.tx_count       = rst ? tx_count_q : '0;
    assign bus.rx_count       = rst ? rx_count_q : '0;

    // TX path: accept a word in T_IDLE, then shift it out one accepted bit at a time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state   <= T_IDLE;
            tx_shreg   <= '0;
            tx_bitcnt  <= '0;
            tx_count_q <= '0;
        end else if (bus.en) begin
            case (tx_state)
                T_IDLE: begin
                    if (bus.tx_valid) begin
                        tx_shreg  <= bus.tx_word;
                        tx_bitcnt <= LAST_BIT;
                        tx_state  <= T_SHIFT;
                    end
                end
                T_SHIFT: begin
                    if (bus.ser_out_ready) begin
                        tx_shreg <= {tx_shreg[DATA_WIDTH-2:0], 1'b0};
                        if (tx_bitcnt == '0) begin
                            tx_state   <= T_IDLE;
                            tx_count_q <= tx_count_q + CNT_ONE;
                        end else begin
                            tx_bitcnt <= tx_bitcnt - BIT_ONE;
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // RX path: collect DATA_WIDTH bits, then present the word until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state   <= R_COLLECT;
            rx_shreg   <= '0;
            rx_bitcnt  <= '0;
            rx_word_q  <= '0;
            rx_count_q <= '0;
        end else if (bus.en) begin
            case (rx_state)
                R_COLLECT: begin
                    if (bus.ser_din_valid) begin
                        rx_shreg <= rx_next[DATA_WIDTH-2:0];
                        if (rx_bitcnt == LAST_BIT) begin
                            rx_word_q <= rx_next;
                            rx_bitcnt <= '0;
                            rx_state  <= R_HOLD;
                        end else begin
                            rx_bitcnt <= rx_bitcnt + BIT_ONE;
                        end
                    end
                end
                R_HOLD: begin
                    if (bus.rx_ready) begin
                        rx_state   <= R_COLLECT;
                        rx_count_q <= rx_count_q + CNT_ONE;
                    end
                end
                default: rx_state <= R_COLLECT;
            endcase
        end
    end
endmodule
